// File: rtl/mem_responder.sv
// mem_responder: fixed-latency line-fill responder with posted writebacks and evict interrupt
module mem_responder #(
    parameter int ADDRBITS   = 32,
    parameter int LINEBITS   = 512,
    parameter int OFFBITS    = 6,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 4,
    parameter int EVICT_HOLD = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                request,
    input  logic [1:0]          operation,
    input  logic [ADDRBITS-1:0] addr,
    input  logic [LINEBITS-1:0] d_in,
    output logic [LINEBITS-1:0] d_out,
    output logic                valid,
    output logic                evict,
    input  logic                evict_req
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    localparam int HW = $clog2(EVICT_HOLD + 1);
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_RFO   = 2'd3;
    // RESPOND is the array-read cycle; valid/d_out are registered out of it one edge later
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] RESPOND = 2'd2;
    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [LINEBITS-1:0] d_out_q, d_out_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                valid_q, valid_d, cool_q;
    logic                pend_q, pend_d, evict_q, evict_d;
    logic                ready, acc_rd, acc_wr, launch;
    logic [LINEBITS-1:0] mem [DEPTH];
    logic                unused_addr;
    assign unused_addr = ^{addr[ADDRBITS-1:OFFBITS+IW], addr[OFFBITS-1:0]};
    assign d_out = d_out_q;
    assign valid = valid_q;
    assign evict = evict_q;
    // next-state: request acceptance, fill countdown, and evict pending/hold tracking
    always_comb begin
        ready   = state_q == IDLE && !valid_q && !cool_q && request;
        acc_rd  = ready && (operation == OP_READ || operation == OP_RFO);
        acc_wr  = ready && operation == OP_WRITE;
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (acc_rd) begin
            state_d = LATENCY == 1 ? RESPOND : BUSY;
            cnt_d   = CW'(LATENCY - 1);
            idx_d   = addr[OFFBITS +: IW];
        end else if (state_q == BUSY) begin
            state_d = !request ? IDLE : (cnt_q == CW'(1) ? RESPOND : BUSY);
            cnt_d   = cnt_q - CW'(1);
        end else if (state_q == RESPOND) begin
            state_d = IDLE;
        end
        valid_d = state_q == RESPOND;
        d_out_d = state_q == RESPOND ? mem[idx_q] : d_out_q;
        launch  = pend_q && !evict_q && state_q == IDLE && !valid_q;
        evict_d = launch ? 1'b1 : (evict_q && (acc_wr || hold_q == HW'(EVICT_HOLD - 1)) ? 1'b0 : evict_q);
        hold_d  = evict_q && evict_d ? hold_q + HW'(1) : '0;
        pend_d  = launch ? 1'b0 : pend_q | (evict_req & ~evict_q);
    end
    // control and output registers, cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            d_out_q <= '0;
            valid_q <= 1'b0;
            cool_q  <= 1'b0;
            pend_q  <= 1'b0;
            evict_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            d_out_q <= d_out_d;
            valid_q <= valid_d;
            cool_q  <= valid_q;
            pend_q  <= pend_d;
            evict_q <= evict_d;
            hold_q  <= hold_d;
        end
    end
    // line store: posted writebacks land on the accepting edge; never reset
    always_ff @(posedge clock) begin
        if (acc_wr) mem[addr[OFFBITS +: IW]] <= d_in;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for fills, writebacks, aborts, evict and async reset
module tb_mem_responder;
    localparam int LAT = 4;
    localparam int EH  = 4;
    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;
    localparam logic [1:0] OP_RFO   = 2'd3;
    typedef struct {
        logic [511:0] data;
        int           due;
    } exp_t;
    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         request = 1'b0;
    logic         evict_req = 1'b0;
    logic [1:0]   operation = OP_NOP;
    logic [31:0]  addr = '0;
    logic [511:0] d_in = '0;
    logic [511:0] d_out;
    logic         valid, evict;
    logic [511:0] a5_line, x_line, y_line, r_line;
    logic [31:0]  ra;
    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           valid_cnt = 0;
    int           base;

    mem_responder #(
        .ADDRBITS(32), .LINEBITS(512), .OFFBITS(6), .DEPTH(256), .LATENCY(LAT), .EVICT_HOLD(EH)
    ) dut (
        .clock(clock), .reset(reset), .request(request), .operation(operation), .addr(addr),
        .d_in(d_in), .d_out(d_out), .valid(valid), .evict(evict), .evict_req(evict_req)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // every valid pulse must match the oldest outstanding fill in data and cycle
    always @(negedge clock) begin
        if (reset && valid) begin
            exp_t e;
            valid_cnt++;
            if (sb.size() == 0) check("spurious_valid", 1'b1, 1'b0);
            else begin
                e = sb.pop_front();
                check("fill_data", d_out, e.data);
                check("fill_cycle", cyc, e.due);
            end
        end
    end

    function automatic logic [511:0] rnd_line();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [511:0] d);
        @(negedge clock);
        request = 1'b1; operation = OP_WRITE; addr = a; d_in = d;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [1:0] op, input logic [511:0] exp, input int extra);
        int start;
        @(negedge clock);
        request = 1'b1; operation = op; addr = a;
        sb.push_back('{exp, cyc + 1 + LAT});
        start = valid_cnt;
        for (int i = 0; i < LAT + 4 && valid_cnt == start; i++) begin
            @(negedge clock);
            if (i == 1) begin operation = OP_NOP; addr = a ^ 32'h40; d_in = ~d_in; end
            #1;
        end
        check("fill_seen", valid_cnt - start, 1);
        operation = op; addr = a;
        repeat (extra) @(negedge clock);
        request = 1'b0; operation = OP_NOP;
        repeat (6) @(negedge clock);
        #1 check("single_valid", valid_cnt - start, 1);
    endtask

    initial begin
        a5_line = {64{8'hA5}};
        x_line  = rnd_line();
        y_line  = rnd_line();
        repeat (3) @(negedge clock);
        #1 check("rst_valid", valid, 1'b0);
        check("rst_evict", evict, 1'b0);
        check("rst_dout", d_out, '0);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        #1 check("idle_valid", valid, 1'b0);
        check("idle_evict", evict, 1'b0);
        check("idle_dout", d_out, '0);
        check("idle_no_fill", valid_cnt, 0);
        do_write(32'h0000_0040, a5_line);
        do_read(32'h0000_0040, OP_READ, a5_line, 0);
        do_write(32'h0000_4040, x_line);
        do_read(32'h0000_0040, OP_RFO, x_line, 0);
        // RFO aborted after two cycles in BUSY
        base = valid_cnt;
        @(negedge clock); request = 1'b1; operation = OP_RFO; addr = 32'h0000_4040;
        @(negedge clock);
        @(negedge clock); request = 1'b0; operation = OP_NOP;
        repeat (8) @(negedge clock);
        #1 check("abort_no_fill", valid_cnt - base, 0);
        do_read(32'h0000_4040, OP_READ, x_line, 0);
        // request held through the turnaround cycle
        do_read(32'h0000_0040, OP_READ, x_line, 2);
        // evict in IDLE, cleared by a WRITE
        @(negedge clock); evict_req = 1'b1;
        @(negedge clock); evict_req = 1'b0; #1 check("ev_pending", evict, 1'b0);
        @(negedge clock); #1 check("ev_rise", evict, 1'b1);
        request = 1'b1; operation = OP_WRITE; addr = 32'h0000_1000; d_in = y_line;
        @(negedge clock); request = 1'b0; operation = OP_NOP; #1 check("ev_clear_on_write", evict, 1'b0);
        do_read(32'h0000_1000, OP_READ, y_line, 0);
        // evict expiring on its own, with a second request absorbed
        @(negedge clock); evict_req = 1'b1;
        @(negedge clock); evict_req = 1'b0; #1 check("eh_pending", evict, 1'b0);
        for (int i = 0; i < EH; i++) begin
            @(negedge clock); evict_req = (i == 1); #1 check("eh_high", evict, 1'b1);
        end
        @(negedge clock); evict_req = 1'b0; #1 check("eh_low", evict, 1'b0);
        repeat (3) begin @(negedge clock); #1 check("eh_no_requeue", evict, 1'b0); end
        // evict requested during BUSY waits for IDLE
        @(negedge clock); request = 1'b1; operation = OP_READ; addr = 32'h0000_1000;
        sb.push_back('{y_line, cyc + 1 + LAT});
        base = valid_cnt;
        @(negedge clock); evict_req = 1'b1;
        @(negedge clock); evict_req = 1'b0;
        for (int i = 0; i < LAT + 4 && valid_cnt == base; i++) begin @(negedge clock); #1; end
        check("evb_fill", valid_cnt - base, 1);
        check("evb_defer0", evict, 1'b0);
        request = 1'b0; operation = OP_NOP;
        @(negedge clock); #1 check("evb_defer1", evict, 1'b0);
        @(negedge clock); #1 check("evb_rise", evict, 1'b1);
        repeat (6) @(negedge clock);
        #1 check("evb_expire", evict, 1'b0);
        // async reset in the middle of BUSY loses the fill
        @(negedge clock); request = 1'b1; operation = OP_READ; addr = 32'h0000_0040;
        repeat (2) @(negedge clock);
        #1 reset = 1'b0; request = 1'b0; operation = OP_NOP;
        #1 check("rstb_valid", valid, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        base = valid_cnt;
        repeat (8) @(negedge clock);
        #1 check("rstb_no_fill", valid_cnt - base, 0);
        do_read(32'h0000_0040, OP_READ, x_line, 0);
        // async reset during the valid cycle drops outputs at once
        @(negedge clock); request = 1'b1; operation = OP_READ; addr = 32'h0000_1000;
        sb.push_back('{y_line, cyc + 1 + LAT});
        base = valid_cnt;
        for (int i = 0; i < LAT + 4 && valid_cnt == base; i++) begin @(negedge clock); #1; end
        check("rstv_fill", valid_cnt - base, 1);
        #1 reset = 1'b0; request = 1'b0; operation = OP_NOP;
        #1 check("rstv_valid", valid, 1'b0);
        check("rstv_dout", d_out, '0);
        @(negedge clock); reset = 1'b1;
        repeat (4) @(negedge clock);
        // random lines read back through aliased addresses
        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            r_line = rnd_line();
            do_write(ra, r_line);
            do_read({ra[31:14] ^ 18'(k + 1), ra[13:6], 6'($urandom)}, (k % 2 == 0) ? OP_READ : OP_RFO, r_line, 0);
        end
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
